// File: rtl/matrix3_window_sequencer_pkg.sv
// Shared types and default geometry for the 3x3 window sequencer.
// Widths are derived with addr_width() so a depth of 1 still yields a 1-bit bus.
package matrix3_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int unsigned C_COLUMNS_DEF     = 32'd640;
  localparam int unsigned C_ROWS_DEF        = 32'd3;
  localparam int unsigned C_FRAME_LINES_DEF = 32'd480;
  localparam int unsigned C_PIXEL_DEPTH_DEF = 32'd8;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

  localparam int unsigned C_COLUMN_W = addr_width(C_COLUMNS_DEF);
  localparam int unsigned C_ROW_W    = addr_width(C_ROWS_DEF);
  localparam int unsigned C_LINE_W   = addr_width(C_FRAME_LINES_DEF);

endpackage

// File: rtl/matrix3_window_sequencer_raster_counter.sv
// Raster position counters: column, frame line and circular buffer row.
// The buffer row restarts at 0 on every frame wrap and on a sync clear.
module raster_counter
  import matrix3_seq_pkg::*;
#(
  parameter int unsigned P_COLUMNS     = C_COLUMNS_DEF,
  parameter int unsigned P_ROWS        = C_ROWS_DEF,
  parameter int unsigned P_FRAME_LINES = C_FRAME_LINES_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sync_clear,
  input  logic                                  advance,
  output logic [addr_width(P_COLUMNS)-1:0]      col,
  output logic [addr_width(P_FRAME_LINES)-1:0]  line,
  output logic [addr_width(P_ROWS)-1:0]         wrow
);

  localparam int unsigned COL_W  = addr_width(P_COLUMNS);
  localparam int unsigned LINE_W = addr_width(P_FRAME_LINES);
  localparam int unsigned ROW_W  = addr_width(P_ROWS);

  logic [COL_W-1:0]  col_r;
  logic [LINE_W-1:0] line_r;
  logic [ROW_W-1:0]  wrow_r;

  // Counter state: sync clear wins, otherwise step once per advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r  <= {COL_W{1'b0}};
      line_r <= {LINE_W{1'b0}};
      wrow_r <= {ROW_W{1'b0}};
    end else if (sync_clear) begin
      col_r  <= {COL_W{1'b0}};
      line_r <= {LINE_W{1'b0}};
      wrow_r <= {ROW_W{1'b0}};
    end else if (advance) begin
      if (col_r == COL_W'(P_COLUMNS - 32'd1)) begin
        col_r <= {COL_W{1'b0}};
        if (line_r == LINE_W'(P_FRAME_LINES - 32'd1)) begin
          line_r <= {LINE_W{1'b0}};
          wrow_r <= {ROW_W{1'b0}};
        end else begin
          line_r <= line_r + LINE_W'(1);
          wrow_r <= (wrow_r == ROW_W'(P_ROWS - 32'd1)) ? {ROW_W{1'b0}} : wrow_r + ROW_W'(1);
        end
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end else begin
      col_r <= col_r;
    end
  end

  assign col  = col_r;
  assign line = line_r;
  assign wrow = wrow_r;

endmodule

// File: rtl/matrix3_window_sequencer.sv
// Sequences raster pixels into a 3-line buffer and requests one 3x3 window per interior pixel.
// Optional macro MATRIX3_SEQ_FRAME_DONE_EN adds O_FRAME_DONE on the last window of a frame.
module matrix3_window_sequencer
  import matrix3_seq_pkg::*;
#(
  parameter int unsigned P_COLUMNS     = C_COLUMNS_DEF,
  parameter int unsigned P_ROWS        = C_ROWS_DEF,
  parameter int unsigned P_FRAME_LINES = C_FRAME_LINES_DEF,
  parameter int unsigned P_PIXEL_DEPTH = C_PIXEL_DEPTH_DEF
) (
  input  logic                                 I_CLK,
  input  logic                                 I_RESET,
  input  logic [P_PIXEL_DEPTH-1:0]             I_PIXEL,
  input  logic                                 I_PIXEL_VALID,
  input  logic                                 I_FRAME_SYNC,
  output logic                                 O_PIXEL_READY,
  output logic [addr_width(P_COLUMNS)-1:0]     O_COLUMN,
  output logic [addr_width(P_ROWS)-1:0]        O_ROW,
  output logic [P_PIXEL_DEPTH-1:0]             O_PIXEL,
  output logic                                 O_WRITE_ENABLE,
  output logic                                 O_READ_ENABLE,
  output logic                                 O_MATRIX_VALID,
  output logic [addr_width(P_COLUMNS)-1:0]     O_CENTER_COLUMN,
  output logic [addr_width(P_FRAME_LINES)-1:0] O_CENTER_LINE
`ifdef MATRIX3_SEQ_FRAME_DONE_EN
  ,
  output logic                                 O_FRAME_DONE
`endif
);

  localparam int unsigned COL_W  = addr_width(P_COLUMNS);
  localparam int unsigned LINE_W = addr_width(P_FRAME_LINES);
  localparam int unsigned ROW_W  = addr_width(P_ROWS);

  state_t            state_r;
  logic [COL_W-1:0]  col_s;
  logic [LINE_W-1:0] line_s;
  logic [ROW_W-1:0]  wrow_s;
  logic              accept_s;
  logic              sync_clear_s;
  logic              advance_s;
  logic              window_s;
  logic [COL_W-1:0]  write_col_s;
  logic [ROW_W-1:0]  write_row_s;
  logic [ROW_W-1:0]  row_prev_s;

  raster_counter #(
    .P_COLUMNS     (P_COLUMNS),
    .P_ROWS        (P_ROWS),
    .P_FRAME_LINES (P_FRAME_LINES)
  ) u_raster_counter (
    .clk        (I_CLK),
    .rst        (I_RESET),
    .sync_clear (sync_clear_s),
    .advance    (advance_s),
    .col        (col_s),
    .line       (line_s),
    .wrow       (wrow_s)
  );

  // Handshake decode and address arithmetic; during WRITE the counters still hold the written position
  always_comb begin
    accept_s     = 1'b0;
    sync_clear_s = 1'b0;
    advance_s    = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s     = I_PIXEL_VALID & O_PIXEL_READY;
        sync_clear_s = I_FRAME_SYNC;
      end
      WRITE:   advance_s = 1'b1;
      default: advance_s = 1'b0;
    endcase
    if (I_FRAME_SYNC) begin
      write_col_s = {COL_W{1'b0}};
      write_row_s = {ROW_W{1'b0}};
    end else begin
      write_col_s = col_s;
      write_row_s = wrow_s;
    end
    if (wrow_s == {ROW_W{1'b0}}) begin
      row_prev_s = ROW_W'(P_ROWS - 32'd1);
    end else begin
      row_prev_s = wrow_s - ROW_W'(1);
    end
    window_s = (line_s >= LINE_W'(2)) && (col_s >= COL_W'(2));
  end

  // Sequencer FSM with registered strobes, addresses and window tag
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_r         <= IDLE;
      O_PIXEL_READY   <= 1'b1;
      O_COLUMN        <= {COL_W{1'b0}};
      O_ROW           <= {ROW_W{1'b0}};
      O_PIXEL         <= {P_PIXEL_DEPTH{1'b0}};
      O_WRITE_ENABLE  <= 1'b0;
      O_READ_ENABLE   <= 1'b0;
      O_MATRIX_VALID  <= 1'b0;
      O_CENTER_COLUMN <= {COL_W{1'b0}};
      O_CENTER_LINE   <= {LINE_W{1'b0}};
`ifdef MATRIX3_SEQ_FRAME_DONE_EN
      O_FRAME_DONE    <= 1'b0;
`endif
    end else begin
      O_MATRIX_VALID <= 1'b0;
`ifdef MATRIX3_SEQ_FRAME_DONE_EN
      O_FRAME_DONE   <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          O_READ_ENABLE <= 1'b0;
          if (accept_s) begin
            O_PIXEL        <= I_PIXEL;
            O_COLUMN       <= write_col_s;
            O_ROW          <= write_row_s;
            O_WRITE_ENABLE <= 1'b1;
            O_PIXEL_READY  <= 1'b0;
            state_r        <= WRITE;
          end else begin
            O_WRITE_ENABLE <= 1'b0;
            O_PIXEL_READY  <= 1'b1;
          end
        end
        WRITE: begin
          O_WRITE_ENABLE <= 1'b0;
          if (window_s) begin
            O_READ_ENABLE   <= 1'b1;
            O_COLUMN        <= col_s - COL_W'(1);
            O_ROW           <= row_prev_s;
            O_CENTER_COLUMN <= col_s - COL_W'(1);
            O_CENTER_LINE   <= line_s - LINE_W'(1);
            O_PIXEL_READY   <= 1'b0;
            state_r         <= READ;
          end else begin
            O_PIXEL_READY <= 1'b1;
            state_r       <= IDLE;
          end
        end
        READ: begin
          O_READ_ENABLE  <= 1'b0;
          O_MATRIX_VALID <= 1'b1;
`ifdef MATRIX3_SEQ_FRAME_DONE_EN
          O_FRAME_DONE   <= (O_CENTER_COLUMN == COL_W'(P_COLUMNS - 32'd2)) &&
                            (O_CENTER_LINE == LINE_W'(P_FRAME_LINES - 32'd2));
`endif
          O_PIXEL_READY  <= 1'b1;
          state_r        <= IDLE;
        end
        default: begin
          O_WRITE_ENABLE <= 1'b0;
          O_READ_ENABLE  <= 1'b0;
          O_PIXEL_READY  <= 1'b1;
          state_r        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix3_window_sequencer.sv
// Self-checking bench for matrix3_window_sequencer on an 8x6 frame (3-line buffer).
// A queue-based event model predicts strobes cycle by cycle; directed tables cover the raster corners.
module tb_matrix3_window_sequencer;

  localparam int COLS  = 8;
  localparam int ROWS  = 3;
  localparam int LINES = 6;

  logic       I_CLK = 1'b0;
  logic       I_RESET = 1'b1;
  logic [7:0] I_PIXEL = 8'h00;
  logic       I_PIXEL_VALID = 1'b0;
  logic       I_FRAME_SYNC = 1'b0;
  logic       O_PIXEL_READY;
  logic [2:0] O_COLUMN;
  logic [1:0] O_ROW;
  logic [7:0] O_PIXEL;
  logic       O_WRITE_ENABLE;
  logic       O_READ_ENABLE;
  logic       O_MATRIX_VALID;
  logic [2:0] O_CENTER_COLUMN;
  logic [2:0] O_CENTER_LINE;
`ifdef MATRIX3_SEQ_FRAME_DONE_EN
  logic       O_FRAME_DONE;
`endif

  always #5 I_CLK = ~I_CLK;

  matrix3_window_sequencer #(
    .P_COLUMNS(COLS), .P_ROWS(ROWS), .P_FRAME_LINES(LINES), .P_PIXEL_DEPTH(8)
  ) dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_PIXEL(I_PIXEL), .I_PIXEL_VALID(I_PIXEL_VALID),
    .I_FRAME_SYNC(I_FRAME_SYNC), .O_PIXEL_READY(O_PIXEL_READY), .O_COLUMN(O_COLUMN),
    .O_ROW(O_ROW), .O_PIXEL(O_PIXEL), .O_WRITE_ENABLE(O_WRITE_ENABLE),
    .O_READ_ENABLE(O_READ_ENABLE), .O_MATRIX_VALID(O_MATRIX_VALID),
    .O_CENTER_COLUMN(O_CENTER_COLUMN), .O_CENTER_LINE(O_CENTER_LINE)
`ifdef MATRIX3_SEQ_FRAME_DONE_EN
    , .O_FRAME_DONE(O_FRAME_DONE)
`endif
  );

  typedef struct {
    logic       we, re, mv, fd;
    logic [2:0] col;
    logic [1:0] row;
    logic [7:0] pix;
    logic [2:0] ccol, cline;
  } ev_t;

  typedef struct {
    logic [7:0] pix;
    logic [2:0] wcol;
    logic [1:0] wrow;
    logic       has_rd;
    logic [2:0] rcol;
    logic [1:0] rrow;
    logic [2:0] ccol, cline;
  } vec_t;

  ev_t  exp_q[$];
  int   mcol = 0, mline = 0;
  int   n_checks = 0, n_errors = 0;
  logic last_accept = 1'b0;
  logic obs_we, obs_re, obs_mv;
  logic [2:0] obs_wcol, obs_rcol, obs_ccol, obs_cline;
  logic [1:0] obs_wrow, obs_rrow;
  logic [7:0] obs_pix;
  int   mv_count = 0, fd_count = 0, wr_count = 0;
  logic [2:0] last_ccol = 3'd0, last_cline = 3'd0;

  function automatic vec_t mk(int pix, int wcol, int wrow, int rd, int rcol, int rrow, int ccol, int cline);
    vec_t v;
    v.pix = 8'(pix); v.wcol = 3'(wcol); v.wrow = 2'(wrow); v.has_rd = 1'(rd);
    v.rcol = 3'(rcol); v.rrow = 2'(rrow); v.ccol = 3'(ccol); v.cline = 3'(cline);
    return v;
  endfunction

  task automatic check(input string name, input logic ok, input string got, input string want);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    mcol = 0;
    mline = 0;
  endfunction

  // Compare this cycle's outputs with the model's prediction and record what was seen
  task automatic check_cycle();
    ev_t  e;
    logic rdy, bad;
    e = '{default: '0};
    if (exp_q.size() > 0) e = exp_q.pop_front();
    rdy = !(e.we || e.re);
    bad = (O_WRITE_ENABLE !== e.we) || (O_READ_ENABLE !== e.re) ||
          (O_MATRIX_VALID !== e.mv) || (O_PIXEL_READY !== rdy);
    if (e.we) bad = bad || (O_COLUMN !== e.col) || (O_ROW !== e.row) || (O_PIXEL !== e.pix);
    if (e.re) bad = bad || (O_COLUMN !== e.col) || (O_ROW !== e.row);
    if (e.re || e.mv) bad = bad || (O_CENTER_COLUMN !== e.ccol) || (O_CENTER_LINE !== e.cline);
`ifdef MATRIX3_SEQ_FRAME_DONE_EN
    bad = bad || (O_FRAME_DONE !== e.fd);
    if (O_FRAME_DONE === 1'b1) fd_count++;
`endif
    check("cycle", !bad,
      $sformatf("rdy=%0b we=%0b re=%0b mv=%0b col=%0d row=%0d pix=%02h c=(%0d,%0d)", O_PIXEL_READY,
        O_WRITE_ENABLE, O_READ_ENABLE, O_MATRIX_VALID, O_COLUMN, O_ROW, O_PIXEL, O_CENTER_COLUMN, O_CENTER_LINE),
      $sformatf("rdy=%0b we=%0b re=%0b mv=%0b col=%0d row=%0d pix=%02h c=(%0d,%0d) at %0t", rdy,
        e.we, e.re, e.mv, e.col, e.row, e.pix, e.ccol, e.cline, $time));
    if (O_WRITE_ENABLE === 1'b1) begin
      obs_we = 1'b1; obs_wcol = O_COLUMN; obs_wrow = O_ROW; obs_pix = O_PIXEL; wr_count++;
    end
    if (O_READ_ENABLE === 1'b1) begin
      obs_re = 1'b1; obs_rcol = O_COLUMN; obs_rrow = O_ROW;
    end
    if (O_MATRIX_VALID === 1'b1) begin
      obs_mv = 1'b1; obs_ccol = O_CENTER_COLUMN; obs_cline = O_CENTER_LINE;
      mv_count++; last_ccol = O_CENTER_COLUMN; last_cline = O_CENTER_LINE;
    end
  endtask

  // One clock: check the previous edge's result, drive inputs, update the raster model on acceptance
  task automatic step(input logic v, input logic [7:0] p, input logic s);
    ev_t w;
    @(negedge I_CLK);
    check_cycle();
    I_PIXEL_VALID = v;
    I_PIXEL = p;
    I_FRAME_SYNC = s;
    last_accept = v && O_PIXEL_READY;
    if (O_PIXEL_READY && s) begin
      mcol = 0;
      mline = 0;
    end
    if (last_accept) begin
      w = '{default: '0};
      w.we = 1'b1; w.col = 3'(mcol); w.row = 2'(mline % ROWS); w.pix = p;
      exp_q.push_back(w);
      if (mline >= 2 && mcol >= 2) begin
        w = '{default: '0};
        w.re = 1'b1; w.col = 3'(mcol - 1); w.row = 2'((mline - 1) % ROWS);
        w.ccol = 3'(mcol - 1); w.cline = 3'(mline - 1);
        exp_q.push_back(w);
        w.re = 1'b0; w.mv = 1'b1; w.col = 3'd0; w.row = 2'd0;
        w.fd = (mcol - 1 == COLS - 2) && (mline - 1 == LINES - 2);
        exp_q.push_back(w);
      end
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        mline++;
        if (mline == LINES) mline = 0;
      end
    end
  endtask

  task automatic send_pixel(input logic [7:0] p, input logic s);
    int guard;
    guard = 0;
    do begin
      step(1'b1, p, s);
      guard++;
    end while (!last_accept && guard < 10);
    check("accept_timeout", last_accept, "no accept", "accept within 10 cycles");
    obs_we = 1'b0; obs_re = 1'b0; obs_mv = 1'b0;
    repeat (3) step(1'b0, 8'h00, 1'b0);
  endtask

  vec_t tbl[27];
  initial begin
    int   k, guard, acc;
    logic ok;
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, limit 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int   k, guard, acc;
    logic ok;
    for (int i = 0; i < 16; i++) tbl[i] = mk(i, i % 8, i / 8, 0, 0, 0, 0, 0);
    tbl[16] = mk(16, 0, 2, 0, 0, 0, 0, 0);
    tbl[17] = mk(17, 1, 2, 0, 0, 0, 0, 0);
    tbl[18] = mk(18, 2, 2, 1, 1, 1, 1, 1);
    tbl[19] = mk(19, 3, 2, 1, 2, 1, 2, 1);
    tbl[20] = mk(20, 4, 2, 1, 3, 1, 3, 1);
    tbl[21] = mk(21, 5, 2, 1, 4, 1, 4, 1);
    tbl[22] = mk(22, 6, 2, 1, 5, 1, 5, 1);
    tbl[23] = mk(23, 7, 2, 1, 6, 1, 6, 1);
    tbl[24] = mk(24, 0, 0, 0, 0, 0, 0, 0);
    tbl[25] = mk(25, 1, 0, 0, 0, 0, 0, 0);
    tbl[26] = mk(26, 2, 0, 1, 1, 2, 1, 2);

    // Reset state
    repeat (3) @(negedge I_CLK);
    ok = (O_PIXEL_READY === 1'b1) && (O_WRITE_ENABLE === 1'b0) && (O_READ_ENABLE === 1'b0) &&
         (O_MATRIX_VALID === 1'b0) && (O_COLUMN === 3'd0) && (O_ROW === 2'd0) && (O_PIXEL === 8'd0) &&
         (O_CENTER_COLUMN === 3'd0) && (O_CENTER_LINE === 3'd0);
    check("reset_state", ok, $sformatf("rdy=%0b we=%0b re=%0b mv=%0b col=%0d row=%0d", O_PIXEL_READY,
          O_WRITE_ENABLE, O_READ_ENABLE, O_MATRIX_VALID, O_COLUMN, O_ROW), "rdy=1, all else 0");
    I_RESET = 1'b0;
    model_reset();

    // Table: first 27 raster pixels of a frame
    for (int i = 0; i < 27; i++) begin
      send_pixel(tbl[i].pix, 1'b0);
      ok = obs_we && (obs_wcol === tbl[i].wcol) && (obs_wrow === tbl[i].wrow) && (obs_pix === tbl[i].pix) &&
           (obs_re === tbl[i].has_rd) && (obs_mv === tbl[i].has_rd);
      if (tbl[i].has_rd)
        ok = ok && (obs_rcol === tbl[i].rcol) && (obs_rrow === tbl[i].rrow) &&
             (obs_ccol === tbl[i].ccol) && (obs_cline === tbl[i].cline);
      check($sformatf("table_%0d", i), ok,
        $sformatf("w(%0d,r%0d) rd=%0b r(%0d,r%0d) c(%0d,%0d)", obs_wcol, obs_wrow, obs_re, obs_rcol, obs_rrow, obs_ccol, obs_cline),
        $sformatf("w(%0d,r%0d) rd=%0b r(%0d,r%0d) c(%0d,%0d)", tbl[i].wcol, tbl[i].wrow, tbl[i].has_rd,
          tbl[i].rcol, tbl[i].rrow, tbl[i].ccol, tbl[i].cline));
    end

    // Frame sync together with a pixel at (5,3)
    send_pixel(8'd27, 1'b0);
    send_pixel(8'd28, 1'b0);
    send_pixel(8'hC3, 1'b1);
    ok = obs_we && (obs_wcol === 3'd0) && (obs_wrow === 2'd0) && !obs_re && !obs_mv;
    check("sync_with_pixel", ok, $sformatf("w(%0d,r%0d) rd=%0b mv=%0b", obs_wcol, obs_wrow, obs_re, obs_mv), "w(0,r0) rd=0 mv=0");

    // Full frame with valid held high
    step(1'b0, 8'h00, 1'b1);
    mv_count = 0; fd_count = 0;
    k = 0; guard = 0;
    while (k < COLS * LINES && guard < 500) begin
      step(1'b1, 8'(k), 1'b0);
      if (last_accept) k++;
      guard++;
    end
    repeat (3) step(1'b0, 8'h00, 1'b0);
    check("frame_pixels", k == COLS * LINES, $sformatf("%0d", k), $sformatf("%0d", COLS * LINES));
    check("frame_windows", mv_count == 24, $sformatf("%0d", mv_count), "24");
    check("frame_last_centre", (last_ccol === 3'd6) && (last_cline === 3'd4),
          $sformatf("(%0d,%0d)", last_ccol, last_cline), "(6,4)");
`ifdef MATRIX3_SEQ_FRAME_DONE_EN
    check("frame_done_count", fd_count == 1, $sformatf("%0d", fd_count), "1");
`endif
    send_pixel(8'h55, 1'b0);
    check("frame_wrap", obs_we && (obs_wcol === 3'd0) && (obs_wrow === 2'd0) && !obs_re,
          $sformatf("w(%0d,r%0d) rd=%0b", obs_wcol, obs_wrow, obs_re), "w(0,r0) rd=0");

    // Valid toggling every other cycle
    wr_count = 0; acc = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'(i % 2), 8'(acc), 1'b0);
      if (last_accept) acc++;
    end
    repeat (3) step(1'b0, 8'h00, 1'b0);
    check("toggle_writes", wr_count == acc, $sformatf("%0d writes", wr_count), $sformatf("%0d", acc));

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 63) == 0));
    repeat (3) step(1'b0, 8'h00, 1'b0);

    // Reset while READ is in progress
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 18; i++) send_pixel(8'(i), 1'b0);
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    @(negedge I_CLK);
    check_cycle();
    #1 I_RESET = 1'b1;
    #1;
    check("reset_drops_read", (O_READ_ENABLE === 1'b0) && (O_PIXEL_READY === 1'b1) && (O_MATRIX_VALID === 1'b0),
          $sformatf("re=%0b rdy=%0b mv=%0b", O_READ_ENABLE, O_PIXEL_READY, O_MATRIX_VALID), "re=0 rdy=1 mv=0");
    model_reset();
    @(negedge I_CLK);
    check_cycle();
    I_RESET = 1'b0;
    mv_count = 0;
    repeat (3) step(1'b0, 8'h00, 1'b0);
    check("no_valid_after_reset", mv_count == 0, $sformatf("%0d", mv_count), "0");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
